// File: rtl/rst_req_ctrl.sv
// Reset-request initiator: gathers enabled reset requests and drives a minimum-width,
// acknowledged reset request. The optional ack-timeout escalation is enabled by RST_REQ_CTRL_ESCALATE_EN.
module rst_req_ctrl #(
  parameter int unsigned NumSrc           = 4,
  parameter int unsigned MinPulseCycles   = 16,
  parameter int unsigned AckTimeoutCycles = 1024
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumSrc-1:0] req_i,
  input  logic [NumSrc-1:0] req_en_i,
  input  logic              rst_ack_i,
  input  logic              cause_clr_i,
  output logic              rst_req_o,
  output logic              busy_o,
  output logic [NumSrc-1:0] cause_o,
  output logic              cause_valid_o,
  output logic              esc_o
);

  localparam int unsigned     CntW   = $clog2(MinPulseCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MinPulseCycles - 1);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StAssert  = 2'd1;
  localparam logic [1:0] StWaitRel = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              rst_req_q, rst_req_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [NumSrc-1:0] cause_q, cause_d;
  logic              cause_valid_q, cause_valid_d;
  logic [NumSrc-1:0] eff;

  assign eff = req_i & req_en_i;

  always_comb begin
    state_d       = state_q;
    rst_req_d     = rst_req_q;
    cnt_d         = cnt_q;
    cause_d       = cause_q;
    cause_valid_d = cause_valid_q;
    case (state_q)
      StIdle: begin
        if (|eff) begin
          state_d       = StAssert;
          rst_req_d     = 1'b1;
          cnt_d         = '0;
          cause_d       = eff;
          cause_valid_d = 1'b1;
        end else if (cause_clr_i) begin
          cause_d       = '0;
          cause_valid_d = 1'b0;
        end
      end
      StAssert: begin
        // Late sources fold into the event already in flight.
        cause_d = cause_q | eff;
        if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntW'(1);
        end
        if ((cnt_q == CntMax) && rst_ack_i) begin
          state_d   = StWaitRel;
          rst_req_d = 1'b0;
        end
      end
      StWaitRel: begin
        if (!rst_ack_i) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d   = StIdle;
        rst_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      rst_req_q     <= 1'b0;
      cnt_q         <= '0;
      cause_q       <= '0;
      cause_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rst_req_q     <= rst_req_d;
      cnt_q         <= cnt_d;
      cause_q       <= cause_d;
      cause_valid_q <= cause_valid_d;
    end
  end

  assign rst_req_o     = rst_req_q;
  assign busy_o        = (state_q != StIdle);
  assign cause_o       = cause_q;
  assign cause_valid_o = cause_valid_q;

`ifdef RST_REQ_CTRL_ESCALATE_EN
  localparam int unsigned     TmoW   = $clog2(AckTimeoutCycles);
  localparam logic [TmoW-1:0] TmoMax = TmoW'(AckTimeoutCycles - 1);

  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            esc_q, esc_d;

  always_comb begin
    tmo_d = tmo_q;
    esc_d = esc_q;
    // Holding the counter clear in IDLE gives a fresh count on every ASSERT entry.
    if (state_q == StIdle) begin
      tmo_d = '0;
    end else if (state_q == StAssert) begin
      if (tmo_q == TmoMax) begin
        esc_d = 1'b1;
      end else if (!rst_ack_i) begin
        tmo_d = tmo_q + TmoW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_q <= '0;
      esc_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      esc_q <= esc_d;
    end
  end

  assign esc_o = esc_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^AckTimeoutCycles;
  assign esc_o          = 1'b0;
`endif

endmodule

// File: tb/tb_rst_req_ctrl.sv
// Scoreboard bench for rst_req_ctrl: expected pulses are queued by the stimulus and
// checked by a monitor when each rst_req_o pulse ends; state checks are made inline.
module tb_rst_req_ctrl;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic [3:0] req    = 4'h0;
  logic [3:0] req_en = 4'hF;
  logic       ack    = 1'b0;
  logic       clr    = 1'b0;
  logic       rst_req, busy, cause_valid, esc;
  logic [3:0] cause;

`ifdef RST_REQ_CTRL_ESCALATE_EN
  localparam logic ExpEsc = 1'b1;
`else
  localparam logic ExpEsc = 1'b0;
`endif

  typedef struct {
    int         width;
    logic [3:0] cause;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  rst_req_ctrl #(
    .NumSrc          (4),
    .MinPulseCycles  (16),
    .AckTimeoutCycles(32)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_i        (req),
    .req_en_i     (req_en),
    .rst_ack_i    (ack),
    .cause_clr_i  (clr),
    .rst_req_o    (rst_req),
    .busy_o       (busy),
    .cause_o      (cause),
    .cause_valid_o(cause_valid),
    .esc_o        (esc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int width, input logic [3:0] c);
    exp_t e;
    e.width = width;
    e.cause = c;
    sb_q.push_back(e);
  endtask

  task automatic wait_req_low(input int limit);
    int n = 0;
    while (rst_req && n < limit) begin
      tick();
      n++;
    end
    chk("req_released", {31'd0, rst_req}, 32'd0);
  endtask

  // Pulse has ended with ack still high; drop ack and expect IDLE one cycle later.
  task automatic finish_event();
    wait_req_low(200);
    chk("busy_in_wait_rel", {31'd0, busy}, 32'd1);
    ack = 1'b0;
    tick();
    chk("busy_after_ack_fall", {31'd0, busy}, 32'd0);
  endtask

  // Monitor: measure each rst_req_o pulse and compare against the queue head.
  initial begin
    int   width;
    exp_t e;
    width = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        width = 0;
      end else if (rst_req) begin
        width = width + 1;
      end else if (width > 0) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_pulse_width", width, 0);
        end else begin
          e = sb_q.pop_front();
          chk("pulse_width", width, e.width);
          chk("pulse_cause", {28'd0, cause}, {28'd0, e.cause});
          chk("pulse_cause_valid", {31'd0, cause_valid}, 32'd1);
        end
        width = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rst_req", {31'd0, rst_req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cause", {28'd0, cause}, 32'd0);
    chk("rst_cause_valid", {31'd0, cause_valid}, 32'd0);
    chk("rst_esc", {31'd0, esc}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: single-cycle pulse, early ack -> minimum width
    req = 4'b0010;
    tick();
    req = 4'b0000;
    chk("t1_latency_req", {31'd0, rst_req}, 32'd1);
    chk("t1_latency_busy", {31'd0, busy}, 32'd1);
    push(16, 4'b0010);
    repeat (2) tick();
    ack = 1'b1;
    finish_event();

    // 2: disabled source ignored, then enabled
    req_en = 4'b1110;
    req    = 4'b0001;
    repeat (2) tick();
    chk("t2_masked_busy", {31'd0, busy}, 32'd0);
    chk("t2_masked_req", {31'd0, rst_req}, 32'd0);
    req_en = 4'b1111;
    tick();
    req = 4'b0000;
    chk("t2_enabled_busy", {31'd0, busy}, 32'd1);
    chk("t2_enabled_cause", {28'd0, cause}, 32'h1);
    push(16, 4'b0001);
    ack = 1'b1;
    finish_event();

    // 3: slow ack and late-source merge
    req = 4'b0100;
    tick();
    req = 4'b0000;
    push(41, 4'b1100);
    repeat (4) tick();
    req = 4'b1000;
    tick();
    req = 4'b0000;
    repeat (35) tick();
    ack = 1'b1;
    finish_event();

    // 4: cause clear interactions
    clr = 1'b1;
    req = 4'b0001;
    tick();
    clr = 1'b0;
    req = 4'b0000;
    chk("t4_req_wins_cause", {28'd0, cause}, 32'h1);
    chk("t4_req_wins_valid", {31'd0, cause_valid}, 32'd1);
    push(16, 4'b0001);
    ack = 1'b1;
    finish_event();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t4_clr_cause", {28'd0, cause}, 32'h0);
    chk("t4_clr_valid", {31'd0, cause_valid}, 32'd0);
    ack = 1'b1;
    repeat (2) tick();
    chk("t4_idle_ack_busy", {31'd0, busy}, 32'd0);
    chk("t4_idle_ack_valid", {31'd0, cause_valid}, 32'd0);
    ack = 1'b0;
    tick();
    req = 4'b0010;
    tick();
    req = 4'b0000;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t4_clr_in_assert_cause", {28'd0, cause}, 32'h2);
    chk("t4_clr_in_assert_valid", {31'd0, cause_valid}, 32'd1);
    push(16, 4'b0010);
    ack = 1'b1;
    wait_req_low(200);
    req = 4'b0100;
    tick();
    chk("t4_wait_rel_ignore", {28'd0, cause}, 32'h2);
    ack = 1'b0;
    tick();
    chk("t4_back_to_idle", {31'd0, busy}, 32'd0);
    tick();
    req = 4'b0000;
    chk("t4_level_retrigger_busy", {31'd0, busy}, 32'd1);
    chk("t4_level_retrigger_cause", {28'd0, cause}, 32'h4);
    push(16, 4'b0100);
    ack = 1'b1;
    finish_event();

    // 5: asynchronous reset mid-ASSERT
    req = 4'b0001;
    tick();
    req = 4'b0000;
    repeat (6) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_rst_req", {31'd0, rst_req}, 32'd0);
    chk("t5_async_busy", {31'd0, busy}, 32'd0);
    chk("t5_async_cause", {28'd0, cause}, 32'h0);
    chk("t5_async_valid", {31'd0, cause_valid}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("t5_after_rst_busy", {31'd0, busy}, 32'd0);

    // 6: ack timeout escalation (esc stays low in the default build)
    req = 4'b0001;
    tick();
    req = 4'b0000;
    repeat (31) tick();
    chk("t6_esc_before_timeout", {31'd0, esc}, 32'd0);
    chk("t6_req_held_32", {31'd0, rst_req}, 32'd1);
    tick();
    chk("t6_esc_at_timeout", {31'd0, esc}, {31'd0, ExpEsc});
    chk("t6_req_held_33", {31'd0, rst_req}, 32'd1);
    ack = 1'b1;
    push(33, 4'b0001);
    finish_event();
    chk("t6_esc_sticky", {31'd0, esc}, {31'd0, ExpEsc});

    repeat (3) tick();
    chk("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
